// File: rtl/key_debounce_nch_pkg.sv
// Shared helpers for the key debouncer: ms-to-cycle conversion, per-channel event type and
// parameter sanity checks used at elaboration time.
package key_pkg;

    // Combinational strobe pair a channel is about to register.
    typedef struct packed {
        logic press;
        logic rel;
    } key_evt_t;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int unsigned db_cyc(input int unsigned clk_hz, input int unsigned ms);
        return ms_to_cyc(clk_hz, ms);
    endfunction

    function automatic int unsigned hold_cyc(input int unsigned clk_hz, input int unsigned ms);
        return ms_to_cyc(clk_hz, ms);
    endfunction

    function automatic int unsigned repeat_cyc(input int unsigned clk_hz, input int unsigned ms);
        return ms_to_cyc(clk_hz, ms);
    endfunction

    function automatic bit db_cyc_ok(input int unsigned db);
        return db >= 2;
    endfunction

    function automatic bit repeat_cfg_ok(input int unsigned hold, input int unsigned rep);
        return (rep >= 1) && (rep <= hold);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce counter, press/release strobes and, when
// KEY_DEBOUNCE_AUTOREPEAT_EN is defined, a hold-to-repeat counter.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DB_CYC     = 4,
    parameter int unsigned ACTIVE_LOW = 1
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int unsigned HOLD_CYC   = 10,
    parameter int unsigned REPEAT_CYC = 3
`endif
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     key_i,
    output logic     level_o,
    output logic     press_o,
    output logic     rel_o,
    output logic     rpt_o,
    output key_evt_t evt_o
);

    localparam int unsigned    CntW    = $clog2(DB_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYC - 1);
    localparam logic           IdleLvl = (ACTIVE_LOW != 0);

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            sample;

    always_comb begin
        sync_d  = {sync_q[0], key_i};
        sample  = sync_q[1] ^ IdleLvl;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            level_d = sample;
            cnt_d   = '0;
            press_d = sample;
            rel_d   = ~sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser resets to the released pin level so a held key re-reports as a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= {2{IdleLvl}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign rel_o       = rel_q;
    assign evt_o.press = press_d;
    assign evt_o.rel   = rel_d;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned     HoldW      = $clog2(HOLD_CYC + 1);
    localparam logic [HoldW-1:0] HoldMax    = HoldW'(HOLD_CYC - 1);
    localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_CYC - REPEAT_CYC);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             rpt_q, rpt_d;

    // The press cycle sees level_q == 0 and the release cycle is masked, so both clear.
    always_comb begin
        hold_d = '0;
        rpt_d  = 1'b0;
        if (level_q && !rel_d) begin
            if (hold_q == HoldMax) begin
                rpt_d  = 1'b1;
                hold_d = HoldReload;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rpt_q  <= rpt_d;
        end
    end

    assign rpt_o = rpt_q;
`else
    assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_nch.sv
// N-channel key conditioner with independent per-channel debounce and a shared event flag.
// Auto-repeat is built only when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module key_debounce_nch
    import key_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned N_KEYS      = 2,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned ACTIVE_LOW  = 1,
    parameter int unsigned HOLD_MS     = 500,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic              XTAL_OSC,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              key_flag
);

    localparam int unsigned DB_CYC     = db_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned HOLD_CYC   = hold_cyc(CLK_HZ, HOLD_MS);
    localparam int unsigned REPEAT_CYC = repeat_cyc(CLK_HZ, REPEAT_MS);

    if (N_KEYS == 0) begin : g_bad_nkeys
        $error("key_debounce_nch: N_KEYS must be at least 1");
    end
    if (!db_cyc_ok(DB_CYC)) begin : g_bad_db
        $error("key_debounce_nch: DB_CYC must be at least 2");
    end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    if (!repeat_cfg_ok(HOLD_CYC, REPEAT_CYC)) begin : g_bad_rpt
        $error("key_debounce_nch: need 1 <= REPEAT_CYC <= HOLD_CYC");
    end
`else
    localparam int unsigned unused_rpt_cfg = HOLD_CYC ^ REPEAT_CYC;
`endif

    key_evt_t chan_evt [N_KEYS];
    logic     key_flag_q, key_flag_d;

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_chan
        key_debounce_chan #(
            .DB_CYC     (DB_CYC),
            .ACTIVE_LOW (ACTIVE_LOW)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            ,
            .HOLD_CYC   (HOLD_CYC),
            .REPEAT_CYC (REPEAT_CYC)
`endif
        ) u_chan (
            .clk_i   (XTAL_OSC),
            .rst_i   (rst),
            .key_i   (key_in[i]),
            .level_o (key_level[i]),
            .press_o (key_press[i]),
            .rel_o   (key_release[i]),
            .rpt_o   (key_repeat[i]),
            .evt_o   (chan_evt[i])
        );
    end

    // OR the channels' next-state strobes so the flag registers alongside them.
    always_comb begin
        key_flag_d = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            key_flag_d = key_flag_d | chan_evt[i].press | chan_evt[i].rel;
        end
    end

    always_ff @(posedge XTAL_OSC) begin
        if (rst) begin
            key_flag_q <= 1'b0;
        end else begin
            key_flag_q <= key_flag_d;
        end
    end

    assign key_flag = key_flag_q;

endmodule
